game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level game-flow controller for the breakout datapath. It drives the ball's run/start level, counts lives, score and remaining blocks, and sequences the phases: idle, serve delay, play, game over and win.
- It sits between the board push-button (debounced upstream) and the ball block.
- It consumes the ball's endgame flag and the block-collision flag. Its status outputs go to the VGA/HEX display logic.

Parameters:
- LIVES, 3: lives loaded at game start (1..MAX_LIVES).
- MAX_LIVES, 9: cap on the lives counter.
- NUM_BLOCKS, 40: blocks loaded at game start (1..255).
- POINTS, 10: score added per block hit.
- SERVE_CYCLES, 50000000: cycles the ball is held parked before each serve (minimum 2).
- EXTRA_LIFE_PTS, 100: points per bonus life; used only with the optional feature.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- start_btn, input, 1: debounced start button, level.
- endgame, input, 1: ball fell below the paddle line. Level; stays high until ball_run drops.
- hit_block, input, 1: ball is colliding with a block. Level; may stay high for several cycles.
- ball_run, output, 1: ball start level. 0 parks the ball at the centre and clears its endgame.
- lives, output, 4: remaining lives.
- score, output, 14: binary score, saturating at 9999.
- blocks_left, output, 8: blocks not yet hit.
- state, output, 3: IDLE=0, SERVE=1, PLAY=2, OVER=3, WON=4.
- game_over, output, 1: high while in OVER.
- game_won, output, 1: high while in WON.

Behaviour:
- Reset values:
  - state=IDLE, ball_run=0, lives=LIVES, score=0, blocks_left=NUM_BLOCKS.
  - game_over=0, game_won=0, serve counter=0.
  - Edge registers for start_btn and hit_block = 0; bonus accumulator = 0.
- Reset asserted mid-operation forces all of the above on the next edge, in every state.
- Edge detection:
  - start_edge = start_btn & ~start_prev; hit_edge = hit_block & ~hit_prev.
  - Both prev registers update every cycle in all states.
  - Only rising edges act; a held hit_block counts once.
- All outputs are registered.
- IDLE:
  - ball_run=0.
  - On start_edge: reload lives=LIVES, score=0, blocks_left=NUM_BLOCKS, counter=0, and go to SERVE.
- SERVE:
  - ball_run=0; the counter increments each cycle.
  - When counter==SERVE_CYCLES-1: go to PLAY, clear the counter. SERVE therefore lasts exactly SERVE_CYCLES cycles.
  - start_btn and hit_edge are ignored.
- PLAY:
  - ball_run=1.
  - On hit_edge with blocks_left>0:
    - blocks_left decrements.
    - score = min(score+POINTS, 9999).
    - If the new blocks_left==0, go to WON.
  - On endgame (evaluated after the hit):
    - If a hit in the same cycle emptied the blocks, WON wins and lives are unchanged.
    - Otherwise lives decrements.
    - If the new lives==0, go to OVER; else go to SERVE with counter=0.
  - endgame is sampled only in PLAY. The ball's held endgame therefore costs exactly one life, because ball_run falls on the next cycle.
- OVER / WON:
  - ball_run=0; game_over or game_won high respectively.
  - On start_edge: reload exactly as in IDLE and go to SERVE.
- Latency:
  - start_edge in cycle n gives state=SERVE in n+1.
  - endgame in cycle n gives ball_run=0 and the lives update in n+1.
  - hit_edge in cycle n gives the score and blocks_left update in n+1.
- Arithmetic guards:
  - lives never underflows; the decrement happens only when lives>0.
  - blocks_left never underflows.
  - The score saturation comparison is done in 15 bits.

Optional Feature:
- Macro: EXTRA_LIFE_EN.
- When defined:
  - A 14-bit accumulator adds POINTS on each counted hit.
  - When the accumulator reaches ≥EXTRA_LIFE_PTS, subtract EXTRA_LIFE_PTS in the same cycle. Also increment lives if lives<MAX_LIVES; at the cap the bonus is discarded.
  - The accumulator clears on reset and on game reload.
  - A bonus life and a life loss in the same cycle net to zero change. In that case the OVER check uses the net value.
- When undefined: no accumulator; lives change only by reload and loss.

Test Plan (LIVES=3, NUM_BLOCKS=4, POINTS=10, SERVE_CYCLES=4, EXTRA_LIFE_PTS=30 where enabled):
- Reset, then pulse start_btn high for 1 cycle → state=SERVE next cycle; ball_run=0 for exactly 4 cycles, then state=PLAY with ball_run=1; lives=3, score=0, blocks_left=4.
- In PLAY, hold hit_block high for 5 cycles, then low, then high for 1 cycle → score=20, blocks_left=2 (one count per rising edge).
- In PLAY, hold endgame high for 10 cycles → lives=2 one cycle after endgame rises, state=SERVE, ball_run=0; a second loss does not occur.
- Three endgame events across three serves → lives=0, state=OVER, game_over=1; a start_btn edge reloads lives=3, score=0 and enters SERVE.
- Fourth hit_edge in the same cycle as endgame → blocks_left=0, score=40, lives unchanged, state=WON, game_won=1.
- With EXTRA_LIFE_EN: three hits → lives=4 after the third; assert reset during SERVE → next cycle all outputs at reset values, state=IDLE.

Source files
------------

// File: rtl/game_sequencer.sv
// Breakout game-flow controller: serve delay, lives, score and block count, win/lose phases.
// Define EXTRA_LIFE_EN to award a bonus life every EXTRA_LIFE_PTS points (capped at MAX_LIVES).
module game_sequencer #(
    parameter int LIVES          = 3,
    parameter int MAX_LIVES      = 9,
    parameter int NUM_BLOCKS     = 40,
    parameter int POINTS         = 10,
    parameter int SERVE_CYCLES   = 50000000,
    parameter int EXTRA_LIFE_PTS = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        endgame,
    input  logic        hit_block,
    output logic        ball_run,
    output logic [3:0]  lives,
    output logic [13:0] score,
    output logic [7:0]  blocks_left,
    output logic [2:0]  state,
    output logic        game_over,
    output logic        game_won
);

    localparam int CNT_W = $clog2(SERVE_CYCLES);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_CYCLES - 1);

    if (LIVES < 1 || LIVES > MAX_LIVES || MAX_LIVES > 15 || NUM_BLOCKS < 1 ||
        NUM_BLOCKS > 255 || SERVE_CYCLES < 2 || EXTRA_LIFE_PTS < 1) begin : g_bad_params
        $error("game_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_OVER  = 3'd3,
        S_WON   = 3'd4
    } state_t;

    state_t           cur, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       lives_n;
    logic [13:0]      score_n;
    logic [7:0]       blocks_n;
    logic [14:0]      score_sum;
    logic             start_prev, hit_prev, start_edge, hit_edge;
`ifdef EXTRA_LIFE_EN
    logic [13:0]      acc, acc_n;
    logic [14:0]      acc_sum;
`endif

    assign state = cur;

    always_comb begin
        start_edge = start_btn & ~start_prev;
        hit_edge   = hit_block & ~hit_prev;
        state_n    = cur;
        cnt_n      = cnt;
        lives_n    = lives;
        score_n    = score;
        blocks_n   = blocks_left;
        score_sum  = {1'b0, score} + 15'(POINTS);
`ifdef EXTRA_LIFE_EN
        acc_n      = acc;
        acc_sum    = {1'b0, acc} + 15'(POINTS);
`endif
        case (cur)
            S_IDLE, S_OVER, S_WON: begin
                if (start_edge) begin
                    state_n  = S_SERVE;
                    cnt_n    = '0;
                    lives_n  = 4'(LIVES);
                    score_n  = 14'd0;
                    blocks_n = 8'(NUM_BLOCKS);
`ifdef EXTRA_LIFE_EN
                    acc_n    = 14'd0;
`endif
                end
            end
            S_SERVE: begin
                if (cnt == SERVE_LAST) begin
                    state_n = S_PLAY;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_PLAY: begin
                if (hit_edge && blocks_left != 8'd0) begin
                    blocks_n = blocks_left - 8'd1;
                    score_n  = (score_sum > 15'd9999) ? 14'd9999 : score_sum[13:0];
`ifdef EXTRA_LIFE_EN
                    if (acc_sum >= 15'(EXTRA_LIFE_PTS)) begin
                        acc_n = 14'(acc_sum - 15'(EXTRA_LIFE_PTS));
                        if (lives < 4'(MAX_LIVES))
                            lives_n = lives + 4'd1;
                    end else begin
                        acc_n = acc_sum[13:0];
                    end
`endif
                    if (blocks_n == 8'd0)
                        state_n = S_WON;
                end
                // A hit that clears the board beats a simultaneous fall.
                if (endgame && state_n != S_WON) begin
                    if (lives != 4'd0)
                        lives_n = lives_n - 4'd1;
                    if (lives_n == 4'd0) begin
                        state_n = S_OVER;
                    end else begin
                        state_n = S_SERVE;
                        cnt_n   = '0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur         <= S_IDLE;
            cnt         <= '0;
            ball_run    <= 1'b0;
            lives       <= 4'(LIVES);
            score       <= 14'd0;
            blocks_left <= 8'(NUM_BLOCKS);
            game_over   <= 1'b0;
            game_won    <= 1'b0;
            start_prev  <= 1'b0;
            hit_prev    <= 1'b0;
`ifdef EXTRA_LIFE_EN
            acc         <= 14'd0;
`endif
        end else begin
            cur         <= state_n;
            cnt         <= cnt_n;
            ball_run    <= (state_n == S_PLAY);
            lives       <= lives_n;
            score       <= score_n;
            blocks_left <= blocks_n;
            game_over   <= (state_n == S_OVER);
            game_won    <= (state_n == S_WON);
            start_prev  <= start_btn;
            hit_prev    <= hit_block;
`ifdef EXTRA_LIFE_EN
            acc         <= acc_n;
`endif
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: per-scenario stimulus tables, expected output vectors queued and
// compared one cycle after each stimulus step.
module tb_game_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_btn = 1'b0;
    logic        endgame = 1'b0;
    logic        hit_block = 1'b0;
    logic        ball_run;
    logic [3:0]  lives;
    logic [13:0] score;
    logic [7:0]  blocks_left;
    logic [2:0]  state;
    logic        game_over;
    logic        game_won;

`ifdef EXTRA_LIFE_EN
    localparam int BONUS = 1;
`else
    localparam int BONUS = 0;
`endif

    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    game_sequencer #(
        .LIVES(3), .MAX_LIVES(9), .NUM_BLOCKS(4), .POINTS(10),
        .SERVE_CYCLES(4), .EXTRA_LIFE_PTS(30)
    ) dut (
        .clock(clock), .reset(reset), .start_btn(start_btn), .endgame(endgame),
        .hit_block(hit_block), .ball_run(ball_run), .lives(lives), .score(score),
        .blocks_left(blocks_left), .state(state), .game_over(game_over), .game_won(game_won)
    );

    always #5 clock = ~clock;

    // Expected vector: {state, ball_run, lives, score, blocks_left, game_over, game_won}
    function automatic logic [31:0] pk(logic [2:0] st, logic br, logic [3:0] lv,
                                       logic [13:0] sc, logic [7:0] bl);
        return {st, br, lv, sc, bl, st == 3'd3, st == 3'd4};
    endfunction

    function automatic logic [31:0] obs();
        return {state, ball_run, lives, score, blocks_left, game_over, game_won};
    endfunction

    task automatic test_reset();
        logic [31:0] got, want;
        int n;
        reset = 1'b1;
        {start_btn, endgame, hit_block} = 3'b000;
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(pk(3'd0, 1'b0, 4'd3, 14'd0, 8'd4));
        got = obs();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_state: got=%h want=%h", got, want);
        end
        reset = 1'b0;
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) begin
            hit_block = i[0];
            exp_q.push_back(pk(3'd0, 1'b0, 4'd3, 14'd0, 8'd4));
            @(posedge clock); #1;
            got = obs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL idle[%0d]: got=%h want=%h", i, got, want);
            end
        end
        hit_block = 1'b0;
        @(posedge clock); #1;
    endtask

    // stim bits: {reset, start_btn, endgame, hit_block}
    task automatic test_start_serve();
        logic [3:0]  st [6];
        logic [31:0] ex [6];
        logic [31:0] got, want;
        st = '{4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        ex = '{pk(1, 0, 3, 0, 4), pk(1, 0, 3, 0, 4), pk(1, 0, 3, 0, 4),
               pk(1, 0, 3, 0, 4), pk(2, 1, 3, 0, 4), pk(2, 1, 3, 0, 4)};
        for (int i = 0; i < 6; i++) begin
            {reset, start_btn, endgame, hit_block} = st[i];
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got = obs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL start_serve[%0d]: got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_hits();
        logic [3:0]  st [8];
        logic [31:0] ex [8];
        logic [31:0] got, want;
        st = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
        ex = '{pk(2, 1, 3, 10, 3), pk(2, 1, 3, 10, 3), pk(2, 1, 3, 10, 3), pk(2, 1, 3, 10, 3),
               pk(2, 1, 3, 10, 3), pk(2, 1, 3, 10, 3), pk(2, 1, 3, 20, 2), pk(2, 1, 3, 20, 2)};
        for (int i = 0; i < 8; i++) begin
            {reset, start_btn, endgame, hit_block} = st[i];
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got = obs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL hits[%0d]: got=%h want=%h", i, got, want);
            end
        end
    endtask

    // endgame is held through the serve, as the ball does until ball_run drops
    task automatic test_endgame_held();
        logic [3:0]  st [6];
        logic [31:0] ex [6];
        logic [31:0] got, want;
        st = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0000, 4'b0000};
        ex = '{pk(1, 0, 2, 20, 2), pk(1, 0, 2, 20, 2), pk(1, 0, 2, 20, 2),
               pk(1, 0, 2, 20, 2), pk(2, 1, 2, 20, 2), pk(2, 1, 2, 20, 2)};
        for (int i = 0; i < 6; i++) begin
            {reset, start_btn, endgame, hit_block} = st[i];
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got = obs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL endgame_held[%0d]: got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_game_over();
        logic [3:0]  st [14];
        logic [31:0] ex [14];
        logic [31:0] got, want;
        st = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010,
               4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ex = '{pk(1, 0, 1, 20, 2), pk(1, 0, 1, 20, 2), pk(1, 0, 1, 20, 2), pk(1, 0, 1, 20, 2),
               pk(2, 1, 1, 20, 2), pk(3, 0, 0, 20, 2), pk(3, 0, 0, 20, 2), pk(3, 0, 0, 20, 2),
               pk(3, 0, 0, 20, 2), pk(1, 0, 3, 0, 4), pk(1, 0, 3, 0, 4), pk(1, 0, 3, 0, 4),
               pk(1, 0, 3, 0, 4), pk(2, 1, 3, 0, 4)};
        for (int i = 0; i < 14; i++) begin
            {reset, start_btn, endgame, hit_block} = st[i];
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got = obs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL game_over[%0d]: got=%h want=%h", i, got, want);
            end
        end
    endtask

    // last block and a fall in the same cycle: the win takes priority
    task automatic test_win();
        logic [3:0]  st [12];
        logic [31:0] ex [12];
        logic [31:0] got, want;
        logic [3:0]  lb;
        lb = 4'(3 + BONUS);
        st = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000,
               4'b0011, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        ex = '{pk(2, 1, 3, 10, 3), pk(2, 1, 3, 10, 3), pk(2, 1, 3, 20, 2), pk(2, 1, 3, 20, 2),
               pk(2, 1, lb, 30, 1), pk(2, 1, lb, 30, 1), pk(4, 0, lb, 40, 0), pk(4, 0, lb, 40, 0),
               pk(4, 0, lb, 40, 0), pk(1, 0, 3, 0, 4), pk(1, 0, 3, 0, 4), pk(1, 0, 3, 0, 4)};
        for (int i = 0; i < 12; i++) begin
            {reset, start_btn, endgame, hit_block} = st[i];
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got = obs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL win[%0d]: got=%h want=%h", i, got, want);
            end
        end
    endtask

    // reset during SERVE, then again during PLAY with a non-zero score
    task automatic test_reset_mid();
        logic [3:0]  st [10];
        logic [31:0] ex [10];
        logic [31:0] got, want;
        st = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
               4'b0000, 4'b0001, 4'b1000, 4'b0000};
        ex = '{pk(0, 0, 3, 0, 4), pk(0, 0, 3, 0, 4), pk(1, 0, 3, 0, 4), pk(1, 0, 3, 0, 4),
               pk(1, 0, 3, 0, 4), pk(1, 0, 3, 0, 4), pk(2, 1, 3, 0, 4), pk(2, 1, 3, 10, 3),
               pk(0, 0, 3, 0, 4), pk(0, 0, 3, 0, 4)};
        for (int i = 0; i < 10; i++) begin
            {reset, start_btn, endgame, hit_block} = st[i];
            exp_q.push_back(ex[i]);
            @(posedge clock); #1;
            got = obs();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid[%0d]: got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_serve();
        test_hits();
        test_endgame_held();
        test_game_over();
        test_win();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
